// File: rtl/input_switch_pkg.sv
// ============================================================================
// input_switch_pkg : owner-state encoding and shared constants for the router
// Revision: 1.0
// ============================================================================
`default_nettype none

package input_switch_pkg;

    typedef enum logic [1:0] {
        ACT_A = 2'd0,
        GAP   = 2'd1,
        ACT_B = 2'd2
    } owner_state_e;

    localparam logic       c_OWNER_A          = 1'b0;
    localparam logic       c_OWNER_B          = 1'b1;
    localparam logic [7:0] c_IDLE_VAL_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// input_debounce : synchroniser chain plus whole-vector stability filter
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_debounce #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_filtered
);

    localparam logic [7:0] c_FILTER_LEN = 8'(FILTER_LEN);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_filtered;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] w_pin_s;

    assign w_pin_s    = r_sync[SYNC_STAGES-1];
    assign o_filtered = r_filtered;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_cand     <= '0;
            r_filtered <= '0;
            r_cnt      <= 8'd0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            // Any difference restarts the run; the count saturates at FILTER_LEN.
            if (w_pin_s != r_cand) begin
                r_cand <= w_pin_s;
                r_cnt  <= 8'd1;
            end else if (r_cnt < c_FILTER_LEN) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_cnt == c_FILTER_LEN) begin
                r_filtered <= r_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/input_switch_sync.sv
// ============================================================================
// input_switch_sync : debounced input bus routed to CPU A or B, break-before-make
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_switch_sync
    import input_switch_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               FILTER_LEN   = 4,
    parameter int               BLANK_CYCLES = 4,
    parameter logic [WIDTH-1:0] IDLE_VAL     = WIDTH'(c_IDLE_VAL_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_io,
    input  logic [WIDTH-1:0] input_pin,
    output logic [WIDTH-1:0] input_to_A,
    output logic [WIDTH-1:0] input_to_B,
    output logic             valid_a,
    output logic             valid_b,
    output logic             switch_busy,
    output logic [7:0]       switch_count
);

    localparam logic [7:0] c_BLANK_CYCLES = 8'(BLANK_CYCLES);

    logic [SYNC_STAGES-1:0] r_ctr_sync;
    logic                   w_ctr_s;
    logic [WIDTH-1:0]       w_filtered;

    owner_state_e r_state, w_state_next;
    logic [7:0]   r_gap_cnt, w_gap_cnt_next;
    logic         r_prev_owner, w_prev_owner_next;
    logic [7:0]   r_count, w_count_next;

    logic [WIDTH-1:0] r_to_a, r_to_b;
    logic             r_valid_a, r_valid_b, r_busy;

    input_debounce #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .i_pin      (input_pin),
        .o_filtered (w_filtered)
    );

    assign w_ctr_s = r_ctr_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_next      = r_state;
        w_gap_cnt_next    = r_gap_cnt;
        w_prev_owner_next = r_prev_owner;
        w_count_next      = r_count;
        case (r_state)
            ACT_A: begin
                if (w_ctr_s == c_OWNER_B) begin
                    w_state_next      = GAP;
                    w_gap_cnt_next    = c_BLANK_CYCLES;
                    w_prev_owner_next = c_OWNER_A;
                end
            end
            ACT_B: begin
                if (w_ctr_s == c_OWNER_A) begin
                    w_state_next      = GAP;
                    w_gap_cnt_next    = c_BLANK_CYCLES;
                    w_prev_owner_next = c_OWNER_B;
                end
            end
            GAP: begin
                // Exit owner follows ctr_s now, so an aborted request lands back home.
                if (r_gap_cnt <= 8'd1) begin
                    w_gap_cnt_next = 8'd0;
                    w_state_next   = (w_ctr_s == c_OWNER_B) ? ACT_B : ACT_A;
                    if (w_ctr_s != r_prev_owner) begin
                        w_count_next = r_count + 8'd1;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = ACT_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr_sync   <= '0;
            r_state      <= ACT_A;
            r_gap_cnt    <= 8'd0;
            r_prev_owner <= c_OWNER_A;
            r_count      <= 8'd0;
            r_to_a       <= '0;
            r_to_b       <= IDLE_VAL;
            r_valid_a    <= 1'b1;
            r_valid_b    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ctr_sync   <= {r_ctr_sync[SYNC_STAGES-2:0], ctr_io};
            r_state      <= w_state_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_prev_owner <= w_prev_owner_next;
            r_count      <= w_count_next;
            // Outputs track the next state so they stay aligned with valid/busy.
            r_to_a       <= (w_state_next == ACT_A) ? w_filtered : IDLE_VAL;
            r_to_b       <= (w_state_next == ACT_B) ? w_filtered : IDLE_VAL;
            r_valid_a    <= (w_state_next == ACT_A);
            r_valid_b    <= (w_state_next == ACT_B);
            r_busy       <= (w_state_next == GAP);
        end
    end

    assign input_to_A   = r_to_a;
    assign input_to_B   = r_to_b;
    assign valid_a      = r_valid_a;
    assign valid_b      = r_valid_b;
    assign switch_busy  = r_busy;
    assign switch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_input_switch_sync.sv
// ============================================================================
// tb_input_switch_sync : scoreboard bench for input_switch_sync
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_input_switch_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctr_io;
    logic [7:0] input_pin;
    logic [7:0] input_to_A;
    logic [7:0] input_to_B;
    logic       valid_a;
    logic       valid_b;
    logic       switch_busy;
    logic [7:0] switch_count;

    typedef enum int {S_A, S_B, S_VA, S_VB, S_BUSY, S_CNT} sig_e;

    typedef struct {
        int         due;
        sig_e       sig;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    input_switch_sync #(
        .WIDTH        (8),
        .SYNC_STAGES  (2),
        .FILTER_LEN   (4),
        .BLANK_CYCLES (4),
        .IDLE_VAL     (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctr_io       (ctr_io),
        .input_pin    (input_pin),
        .input_to_A   (input_to_A),
        .input_to_B   (input_to_B),
        .valid_a      (valid_a),
        .valid_b      (valid_b),
        .switch_busy  (switch_busy),
        .switch_count (switch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %02h expected %02h", tag, cyc, got, exp);
        end
    endtask

    // Insert keeping the queue ordered by due cycle.
    task automatic exp_at(input int dly, input sig_e s, input logic [7:0] v, input string tag);
        exp_t e;
        int   i;
        e.due = cyc + dly;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].due <= e.due) i++;
        sb.insert(i, e);
    endtask

    task automatic exp_range(input int d0, input int d1, input sig_e s, input logic [7:0] v,
                             input string tag);
        for (int d = d0; d <= d1; d++) exp_at(d, s, v, tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    exp_t       m_e;
    logic [7:0] m_got;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            case (m_e.sig)
                S_A:     m_got = input_to_A;
                S_B:     m_got = input_to_B;
                S_VA:    m_got = {7'd0, valid_a};
                S_VB:    m_got = {7'd0, valid_b};
                S_BUSY:  m_got = {7'd0, switch_busy};
                default: m_got = switch_count;
            endcase
            check(m_e.tag, m_got, m_e.val);
        end
    end

    initial begin
        rst       = 1'b1;
        ctr_io    = 1'b0;
        input_pin = 8'hA5;
        step(3);

        // Reset state
        exp_at(0, S_A,    8'h00, "rst_a");
        exp_at(0, S_B,    8'hFF, "rst_b");
        exp_at(0, S_VA,   8'd1,  "rst_va");
        exp_at(0, S_VB,   8'd0,  "rst_vb");
        exp_at(0, S_BUSY, 8'd0,  "rst_busy");
        exp_at(0, S_CNT,  8'd0,  "rst_cnt");
        rst       = 1'b0;
        input_pin = 8'h00;
        step(10);

        // End-to-end latency: visible after the 8th posedge following the drive
        input_pin = 8'h3C;
        exp_at(7, S_A, 8'h00, "lat_pre");
        exp_at(8, S_A, 8'h3C, "lat_a");
        exp_range(1, 9, S_B, 8'hFF, "lat_b_idle");
        step(12);

        // 3-cycle glitch must be filtered out
        input_pin = 8'h01;
        exp_range(0, 15, S_A, 8'h3C, "glitch3");
        step(3);
        input_pin = 8'h3C;
        step(15);

        // 4-cycle pulse passes for exactly 4 cycles
        input_pin = 8'h01;
        exp_at(7, S_A, 8'h3C, "pulse4_pre");
        exp_range(8, 11, S_A, 8'h01, "pulse4");
        exp_at(12, S_A, 8'h3C, "pulse4_post");
        step(4);
        input_pin = 8'h3C;
        step(12);

        // Switch A -> B
        input_pin = 8'h5A;
        step(12);
        ctr_io = 1'b1;
        exp_at(2, S_A,    8'h5A, "sw_a_before");
        exp_at(2, S_BUSY, 8'd0,  "sw_busy_before");
        exp_range(3, 6, S_BUSY, 8'd1,  "sw_busy");
        exp_range(3, 6, S_A,    8'hFF, "sw_gap_a");
        exp_range(3, 6, S_B,    8'hFF, "sw_gap_b");
        exp_range(3, 6, S_VA,   8'd0,  "sw_gap_va");
        exp_range(3, 6, S_VB,   8'd0,  "sw_gap_vb");
        exp_at(6, S_CNT,  8'd0,  "sw_cnt_gap");
        exp_at(7, S_BUSY, 8'd0,  "sw_busy_end");
        exp_at(7, S_B,    8'h5A, "sw_b");
        exp_at(7, S_A,    8'hFF, "sw_a_idle");
        exp_at(7, S_VB,   8'd1,  "sw_vb");
        exp_at(7, S_VA,   8'd0,  "sw_va");
        exp_at(7, S_CNT,  8'd1,  "sw_cnt");
        step(12);

        // Switch B -> A
        ctr_io = 1'b0;
        exp_at(6, S_BUSY, 8'd1,  "back_busy");
        exp_at(7, S_A,    8'h5A, "back_a");
        exp_at(7, S_VA,   8'd1,  "back_va");
        exp_at(7, S_CNT,  8'd2,  "back_cnt");
        step(12);

        // Aborted request: full gap, back to A, count unchanged
        ctr_io = 1'b1;
        exp_range(3, 6, S_BUSY, 8'd1, "abort_busy");
        exp_at(7, S_BUSY, 8'd0,  "abort_busy_end");
        exp_at(7, S_VA,   8'd1,  "abort_va");
        exp_at(7, S_VB,   8'd0,  "abort_vb");
        exp_at(7, S_A,    8'h5A, "abort_a");
        exp_at(7, S_B,    8'hFF, "abort_b");
        exp_range(3, 9, S_CNT, 8'd2, "abort_cnt");
        step(2);
        ctr_io = 1'b0;
        step(12);

        // Reset during the second gap cycle
        ctr_io = 1'b1;
        step(4);
        exp_at(0, S_BUSY, 8'd1, "mid_gap_busy");
        rst    = 1'b1;
        ctr_io = 1'b0;
        exp_at(1, S_BUSY, 8'd0,  "gaprst_busy");
        exp_at(1, S_VA,   8'd1,  "gaprst_va");
        exp_at(1, S_VB,   8'd0,  "gaprst_vb");
        exp_at(1, S_A,    8'h00, "gaprst_a");
        exp_at(1, S_B,    8'hFF, "gaprst_b");
        exp_at(1, S_CNT,  8'd0,  "gaprst_cnt");
        step(1);
        rst = 1'b0;
        exp_range(1, 12, S_BUSY, 8'd0, "postrst_busy");
        exp_range(1, 12, S_VA,   8'd1, "postrst_va");
        exp_at(7, S_A, 8'h00, "postrst_a_pre");
        exp_at(8, S_A, 8'h5A, "postrst_a");
        step(12);

        // 256 switchovers wrap the counter back to 0
        for (int i = 0; i < 256; i++) begin
            ctr_io = ~ctr_io;
            exp_at(9, S_CNT, 8'(i + 1), "wrap_cnt");
            step(10);
        end
        exp_at(0, S_VA,  8'd1, "wrap_va");
        exp_at(0, S_CNT, 8'd0, "wrap_final");
        step(1);

        for (int k = 0; k < 40 && sb.size() > 0; k++) step(1);
        check("sb_drain", 8'(sb.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
